// File: rtl/rapid_pkg.sv
// Shared types and widths for the RAPID core pipeline.
// Holds the datapath width and the execute-to-memory control bundle.
package rapid_pkg;

   localparam int XLEN = 32;

   typedef struct packed {
      logic       mem;
      logic       iop;
      logic [2:0] fcs_opcode;
      logic [4:0] rd;
   } control_mem_s;

endpackage

// File: rtl/memory_access.sv
// Memory-access stage: passes ALU results through, runs loads/stores on
// a req/ack data bus with timeout, and reports misaligned/illegal/timeout.
// Ports: i_clk, i_rst_n, i_valid/o_ready handshake, i_control_signal,
//   i_rd_output (addr or result), i_rs2 (store data), o_dmem_* / i_dmem_*
//   bus, o_wb_* writeback pulse, o_exc/o_exc_cause exception pulse.
module memory_access
   import rapid_pkg::*;
#(
   parameter int          XLEN        = rapid_pkg::XLEN,
   parameter int unsigned MEM_TIMEOUT = 64
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_valid,
   output logic             o_ready,
   input  control_mem_s     i_control_signal,
   input  logic [XLEN-1:0]  i_rd_output,
   input  logic [XLEN-1:0]  i_rs2,
   output logic             o_dmem_req,
   output logic             o_dmem_we,
   output logic [XLEN-1:0]  o_dmem_addr,
   output logic [XLEN-1:0]  o_dmem_wdata,
   output logic [3:0]       o_dmem_be,
   input  logic             i_dmem_ack,
   input  logic [XLEN-1:0]  i_dmem_rdata,
   output logic             o_wb_valid,
   output logic             o_wb_we,
   output logic [4:0]       o_wb_rd,
   output logic [XLEN-1:0]  o_wb_data,
   output logic             o_exc,
   output logic [1:0]       o_exc_cause
);

   localparam int CW = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

   typedef enum logic {IDLE, BUS} state_e;

   state_e            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [XLEN-1:0]   addr_q, addr_d;
   logic [XLEN-1:0]   wdata_q, wdata_d;
   logic [3:0]        be_q, be_d;
   logic              we_q, we_d;
   logic [1:0]        off_q, off_d;
   logic [2:0]        fcs_q, fcs_d;
   logic [4:0]        rd_q, rd_d;
   logic              wb_valid_q, wb_valid_d;
   logic              wb_we_q, wb_we_d;
   logic [4:0]        wb_rd_q, wb_rd_d;
   logic [XLEN-1:0]   wb_data_q, wb_data_d;
   logic              exc_q, exc_d;
   logic [1:0]        cause_q, cause_d;

   control_mem_s      ctl;
   logic [XLEN-1:0]   a;
   logic              legal;
   logic              misal;
   logic [XLEN-1:0]   ld_sh;
   logic [XLEN-1:0]   ld_val;

   assign ctl = i_control_signal;
   assign a   = i_rd_output;

   always_comb begin
      legal = 1'b0;
      if (ctl.iop) begin
         legal = (ctl.fcs_opcode[2] == 1'b0) && (ctl.fcs_opcode[1:0] != 2'b11);
      end else begin
         legal = (ctl.fcs_opcode[1:0] != 2'b11) && (ctl.fcs_opcode != 3'b110);
      end
      misal = 1'b0;
      if (ctl.fcs_opcode[1:0] == 2'b01) begin
         misal = a[0];
      end else if (ctl.fcs_opcode[1:0] == 2'b10) begin
         misal = (a[1:0] != 2'b00);
      end
   end

   // Halves are always 2-byte aligned here, so one byte-offset shift
   // serves both byte and half extraction.
   always_comb begin
      ld_sh  = i_dmem_rdata >> {off_q, 3'b000};
      ld_val = i_dmem_rdata;
      unique case (fcs_q[1:0])
         2'b00: ld_val = {{(XLEN-8){ld_sh[7] & ~fcs_q[2]}}, ld_sh[7:0]};
         2'b01: ld_val = {{(XLEN-16){ld_sh[15] & ~fcs_q[2]}}, ld_sh[15:0]};
         default: ld_val = i_dmem_rdata;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      be_d       = be_q;
      we_d       = we_q;
      off_d      = off_q;
      fcs_d      = fcs_q;
      rd_d       = rd_q;
      wb_valid_d = 1'b0;
      wb_we_d    = 1'b0;
      wb_rd_d    = '0;
      wb_data_d  = '0;
      exc_d      = 1'b0;
      cause_d    = 2'b00;
      unique case (state_q)
         IDLE: begin
            if (i_valid) begin
               wb_rd_d = ctl.rd;
               if (!ctl.mem) begin
                  wb_valid_d = 1'b1;
                  wb_we_d    = (ctl.rd != 5'd0);
                  wb_data_d  = a;
               end else if (!legal) begin
                  wb_valid_d = 1'b1;
                  exc_d      = 1'b1;
                  cause_d    = 2'b11;
               end else if (misal) begin
                  wb_valid_d = 1'b1;
                  exc_d      = 1'b1;
                  cause_d    = 2'b01;
               end else begin
                  state_d = BUS;
                  cnt_d   = '0;
                  addr_d  = {a[XLEN-1:2], 2'b00};
                  off_d   = a[1:0];
                  fcs_d   = ctl.fcs_opcode;
                  rd_d    = ctl.rd;
                  we_d    = ctl.iop;
                  be_d    = 4'b1111;
                  wdata_d = '0;
                  if (ctl.iop) begin
                     unique case (ctl.fcs_opcode[1:0])
                        2'b00: begin
                           be_d    = 4'b0001 << a[1:0];
                           wdata_d = {(XLEN/8){i_rs2[7:0]}};
                        end
                        2'b01: begin
                           be_d    = a[1] ? 4'b1100 : 4'b0011;
                           wdata_d = {(XLEN/16){i_rs2[15:0]}};
                        end
                        default: wdata_d = i_rs2;
                     endcase
                  end
               end
            end
         end
         BUS: begin
            if (i_dmem_ack || cnt_q == LAST) begin
               state_d    = IDLE;
               wb_valid_d = 1'b1;
               wb_rd_d    = rd_q;
               addr_d     = '0;
               wdata_d    = '0;
               be_d       = '0;
               we_d       = 1'b0;
               // An ack in the final counted cycle beats the timeout.
               if (i_dmem_ack) begin
                  if (!we_q) begin
                     wb_we_d   = (rd_q != 5'd0);
                     wb_data_d = ld_val;
                  end
               end else begin
                  exc_d   = 1'b1;
                  cause_d = 2'b10;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         be_q       <= '0;
         we_q       <= 1'b0;
         off_q      <= '0;
         fcs_q      <= '0;
         rd_q       <= '0;
         wb_valid_q <= 1'b0;
         wb_we_q    <= 1'b0;
         wb_rd_q    <= '0;
         wb_data_q  <= '0;
         exc_q      <= 1'b0;
         cause_q    <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         be_q       <= be_d;
         we_q       <= we_d;
         off_q      <= off_d;
         fcs_q      <= fcs_d;
         rd_q       <= rd_d;
         wb_valid_q <= wb_valid_d;
         wb_we_q    <= wb_we_d;
         wb_rd_q    <= wb_rd_d;
         wb_data_q  <= wb_data_d;
         exc_q      <= exc_d;
         cause_q    <= cause_d;
      end
   end

   assign o_ready      = (state_q == IDLE);
   assign o_dmem_req   = (state_q == BUS);
   assign o_dmem_we    = we_q;
   assign o_dmem_addr  = addr_q;
   assign o_dmem_wdata = wdata_q;
   assign o_dmem_be    = be_q;
   assign o_wb_valid   = wb_valid_q;
   assign o_wb_we      = wb_we_q;
   assign o_wb_rd      = wb_rd_q;
   assign o_wb_data    = wb_data_q;
   assign o_exc        = exc_q;
   assign o_exc_cause  = cause_q;

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: vector table for single-cycle results,
// hand sequences for bus loads/stores, timeout and mid-bus reset.
module tb_memory_access;
   import rapid_pkg::*;

   logic             clk;
   logic             rst_n;
   logic             valid;
   logic             ready;
   control_mem_s     ctl;
   logic [31:0]      rdo;
   logic [31:0]      rs2;
   logic             req;
   logic             we;
   logic [31:0]      addr;
   logic [31:0]      wdata;
   logic [3:0]       be;
   logic             ack;
   logic [31:0]      rdata;
   logic             wb_valid;
   logic             wb_we;
   logic [4:0]       wb_rd;
   logic [31:0]      wb_data;
   logic             exc;
   logic [1:0]       cause;

   int checks = 0;
   int errors = 0;

   memory_access #(.XLEN(32), .MEM_TIMEOUT(4)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(ready),
      .i_control_signal(ctl), .i_rd_output(rdo), .i_rs2(rs2),
      .o_dmem_req(req), .o_dmem_we(we), .o_dmem_addr(addr),
      .o_dmem_wdata(wdata), .o_dmem_be(be), .i_dmem_ack(ack),
      .i_dmem_rdata(rdata), .o_wb_valid(wb_valid), .o_wb_we(wb_we),
      .o_wb_rd(wb_rd), .o_wb_data(wb_data), .o_exc(exc),
      .o_exc_cause(cause)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", name, act, exp);
      end
   endtask

   // Drive one op at a negedge; returns at the negedge after acceptance.
   task automatic issue(input logic m, input logic iop, input logic [2:0] f,
                        input logic [4:0] rd, input logic [31:0] a,
                        input logic [31:0] d);
      ctl.mem = m; ctl.iop = iop; ctl.fcs_opcode = f; ctl.rd = rd;
      rdo = a; rs2 = d; valid = 1'b1;
      @(negedge clk);
      valid = 1'b0;
   endtask

   task automatic bus_op(input string nm, input logic iop,
                         input logic [2:0] f, input logic [4:0] rd,
                         input logic [31:0] a, input logic [31:0] d,
                         input int waits, input logic [31:0] rw,
                         input logic [31:0] e_addr, input logic [3:0] e_be,
                         input logic [31:0] e_wd, input logic e_wbwe,
                         input logic [31:0] e_data);
      issue(1'b1, iop, f, rd, a, d);
      chk({nm, ".req"}, 32'(req), 32'd1);
      chk({nm, ".rdy"}, 32'(ready), 32'd0);
      chk({nm, ".addr"}, addr, e_addr);
      chk({nm, ".be"}, 32'(be), 32'(e_be));
      chk({nm, ".we"}, 32'(we), 32'(iop));
      if (iop) chk({nm, ".wdata"}, wdata, e_wd);
      for (int i = 0; i < waits; i++) begin
         @(negedge clk);
         chk({nm, ".hold"}, {req, be, addr[27:0]}, {1'b1, e_be, e_addr[27:0]});
      end
      ack = 1'b1; rdata = rw;
      @(negedge clk);
      ack = 1'b0;
      chk({nm, ".wbv"}, 32'(wb_valid), 32'd1);
      chk({nm, ".wbwe"}, 32'(wb_we), 32'(e_wbwe));
      chk({nm, ".exc"}, 32'(exc), 32'd0);
      chk({nm, ".reqoff"}, {31'd0, req}, 32'd0);
      if (!iop) chk({nm, ".data"}, wb_data, e_data);
   endtask

   typedef struct {
      logic        m;
      logic        iop;
      logic [2:0]  f;
      logic [4:0]  rd;
      logic [31:0] a;
      logic        e_we;
      logic [31:0] e_data;
      logic        e_exc;
      logic [1:0]  e_cause;
   } vec_t;

   vec_t vt[11];

   initial begin
      int n;
      int bad_v;
      int bad_e;
      vt[0]  = '{1'b0, 1'b0, 3'd0, 5'd5,  32'h0000_00A5, 1'b1, 32'h0000_00A5, 1'b0, 2'd0};
      vt[1]  = '{1'b0, 1'b0, 3'd0, 5'd0,  32'h0000_1234, 1'b0, 32'h0000_1234, 1'b0, 2'd0};
      vt[2]  = '{1'b0, 1'b1, 3'd7, 5'd31, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b0, 2'd0};
      vt[3]  = '{1'b1, 1'b0, 3'd3, 5'd7,  32'h0000_0100, 1'b0, 32'h0, 1'b1, 2'd3};
      vt[4]  = '{1'b1, 1'b1, 3'd4, 5'd7,  32'h0000_0100, 1'b0, 32'h0, 1'b1, 2'd3};
      vt[5]  = '{1'b1, 1'b0, 3'd6, 5'd7,  32'h0000_0100, 1'b0, 32'h0, 1'b1, 2'd3};
      vt[6]  = '{1'b1, 1'b0, 3'd2, 5'd3,  32'h0000_3001, 1'b0, 32'h0, 1'b1, 2'd1};
      vt[7]  = '{1'b1, 1'b0, 3'd1, 5'd3,  32'h0000_2001, 1'b0, 32'h0, 1'b1, 2'd1};
      vt[8]  = '{1'b1, 1'b1, 3'd2, 5'd3,  32'h0000_2002, 1'b0, 32'h0, 1'b1, 2'd1};
      vt[9]  = '{1'b1, 1'b1, 3'd1, 5'd3,  32'h0000_2003, 1'b0, 32'h0, 1'b1, 2'd1};
      vt[10] = '{1'b1, 1'b0, 3'd5, 5'd3,  32'h0000_4003, 1'b0, 32'h0, 1'b1, 2'd1};

      rst_n = 1'b0; valid = 1'b0; ack = 1'b0; rdata = '0;
      ctl = '0; rdo = '0; rs2 = '0;
      #12;
      chk("rst.ready", 32'(ready), 32'd1);
      chk("rst.outs", {req, we, be, wb_valid, wb_we, exc, cause, wb_rd}, 32'd0);
      chk("rst.addr", addr | wdata | wb_data, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      foreach (vt[i]) begin
         issue(vt[i].m, vt[i].iop, vt[i].f, vt[i].rd, vt[i].a, 32'h5555_AAAA);
         chk($sformatf("v%0d.wbv", i), 32'(wb_valid), 32'd1);
         chk($sformatf("v%0d.wbwe", i), 32'(wb_we), 32'(vt[i].e_we));
         chk($sformatf("v%0d.exc", i), {exc, cause}, {vt[i].e_exc, vt[i].e_cause});
         chk($sformatf("v%0d.req", i), 32'(req), 32'd0);
         chk($sformatf("v%0d.rdy", i), 32'(ready), 32'd1);
         if (!vt[i].e_exc) begin
            chk($sformatf("v%0d.data", i), wb_data, vt[i].e_data);
            chk($sformatf("v%0d.rd", i), 32'(wb_rd), 32'(vt[i].rd));
         end
      end
      @(negedge clk);
      chk("pulse.wbv", {wb_valid, exc}, 32'd0);

      bus_op("lb", 1'b0, 3'd0, 5'd9, 32'h0000_1003, 32'h0, 2, 32'h80FF_0000,
             32'h0000_1000, 4'hF, 32'h0, 1'b1, 32'hFFFF_FF80);
      bus_op("lbu", 1'b0, 3'd4, 5'd9, 32'h0000_1003, 32'h0, 2, 32'h80FF_0000,
             32'h0000_1000, 4'hF, 32'h0, 1'b1, 32'h0000_0080);
      bus_op("lh", 1'b0, 3'd1, 5'd4, 32'h0000_1002, 32'h0, 0, 32'h80FF_0000,
             32'h0000_1000, 4'hF, 32'h0, 1'b1, 32'hFFFF_80FF);
      bus_op("lw0", 1'b0, 3'd2, 5'd0, 32'h0000_1004, 32'h0, 1, 32'hDEAD_BEEF,
             32'h0000_1004, 4'hF, 32'h0, 1'b0, 32'hDEAD_BEEF);
      bus_op("sh", 1'b1, 3'd1, 5'd0, 32'h0000_2002, 32'h1234_ABCD, 1, 32'h0,
             32'h0000_2000, 4'b1100, 32'hABCD_ABCD, 1'b0, 32'h0);
      bus_op("sb", 1'b1, 3'd0, 5'd0, 32'h0000_2001, 32'h1234_ABCD, 0, 32'h0,
             32'h0000_2000, 4'b0010, 32'hCDCD_CDCD, 1'b0, 32'h0);
      bus_op("sw", 1'b1, 3'd2, 5'd0, 32'h0000_2008, 32'h1234_ABCD, 0, 32'h0,
             32'h0000_2008, 4'hF, 32'h1234_ABCD, 1'b0, 32'h0);

      // Ack in the last counted cycle wins over the timeout.
      bus_op("lwlast", 1'b0, 3'd2, 5'd6, 32'h0000_1008, 32'h0, 3, 32'h0BAD_F00D,
             32'h0000_1008, 4'hF, 32'h0, 1'b1, 32'h0BAD_F00D);

      issue(1'b1, 1'b1, 3'd2, 5'd0, 32'h0000_2004, 32'h0000_0001);
      n = 0;
      while (req && n < 20) begin
         n++;
         @(negedge clk);
      end
      chk("to.cycles", 32'(n), 32'd4);
      chk("to.exc", {exc, cause, wb_valid, wb_we}, {1'b1, 2'b10, 1'b1, 1'b0});
      chk("to.req", {req, ready}, 32'b01);

      issue(1'b1, 1'b0, 3'd2, 5'd1, 32'h0000_5000, 32'h0);
      chk("rb.req", 32'(req), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rb.reqdrop", {req, ready}, 32'b01);
      @(negedge clk);
      rst_n = 1'b1;
      bad_v = 0; bad_e = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (wb_valid) bad_v++;
         if (exc) bad_e++;
      end
      chk("rb.nowb", 32'(bad_v), 32'd0);
      chk("rb.noexc", 32'(bad_e), 32'd0);
      issue(1'b0, 1'b0, 3'd0, 5'd12, 32'hCAFE_0001, 32'h0);
      chk("rb.next", {wb_valid, wb_we, wb_rd}, {1'b1, 1'b1, 5'd12});
      chk("rb.data", wb_data, 32'hCAFE_0001);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
